mmu_req_dispatcher: RTL and testbench
=====================================

Name: mmu_req_dispatcher

Overview:
Sits between the four MMU request/response sync FIFOs and the allocator core. It round-robin pops the alloc and free request FIFOs and normalises page count to 1/2/4/8. Malformed requests are answered locally with a failure response; valid ones go to the core over valid/ready. Core responses are forwarded into the response FIFOs, muxed with local failures.

Parameters:
ID_W, 13, request id width
IDX_W, 15, page index width
CNT_W, 4, request page-count width
RSN_W, 2, fail-reason width
PAGE_NUM, 3276, total pages; legal indices 0..PAGE_NUM-1

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
alloc_fifo_empty  in  1  alloc request FIFO empty
alloc_fifo_pop  out  1  alloc request FIFO read_en; data valid next cycle
alloc_fifo_data  in  CNT_W+ID_W  {cnt,id}
free_fifo_empty  in  1  free request FIFO empty
free_fifo_pop  out  1  free request FIFO read_en; data valid next cycle
free_fifo_data  in  CNT_W+IDX_W+ID_W  {cnt,idx,id}
core_alloc_valid  out  1  alloc issue valid
core_alloc_ready  in  1  core accepts alloc
core_alloc_data  out  CNT_W+ID_W  {aligned cnt,id}
core_free_valid  out  1  free issue valid
core_free_ready  in  1  core accepts free
core_free_data  out  CNT_W+IDX_W+ID_W  {aligned cnt,idx,id}
core_alloc_rsp_valid  in  1  core alloc response valid
core_alloc_rsp_ready  out  1  = ~alloc_rsp_fifo_full
core_alloc_rsp_data  in  ID_W+IDX_W+RSN_W+1  {id,idx,reason,fail}
core_free_rsp_valid  in  1  core free response valid
core_free_rsp_ready  out  1  = ~free_rsp_fifo_full
core_free_rsp_data  in  ID_W+RSN_W+1  {id,reason,fail}
alloc_rsp_we  out  1  alloc response FIFO write_en
alloc_rsp_data  out  ID_W+IDX_W+RSN_W+1  {id,idx,reason,fail}
alloc_rsp_fifo_full  in  1  alloc response FIFO full
free_rsp_we  out  1  free response FIFO write_en
free_rsp_data  out  ID_W+RSN_W+1  {id,reason,fail}
free_rsp_fifo_full  in  1  free response FIFO full

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All pop/valid/we outputs 0, all data registers 0, local-fail pending flags 0, round-robin pointer favours alloc. Any in-flight popped request is dropped.
- FSM: IDLE -> RD -> CHK -> ISSUE|FAIL -> IDLE.
- IDLE: if either FIFO is non-empty, grant one. When both are non-empty, grant the one not granted last. Latch sel. Go to RD.
- RD: assert the selected pop for exactly 1 cycle. Go to CHK.
- CHK: sample FIFO data and normalise cnt: 1->1, 2->2, 3..4->4, 5..8->8. cnt 0 or >8 fails with reason 1 (BAD_SIZE).
- Free checks, applied in this order after the size check: idx>=PAGE_NUM or idx+aligned>PAGE_NUM fails with reason 2 (OUT_OF_RANGE); idx mod aligned !=0 fails with reason 3 (MISALIGNED).
- CHK exit: register the result; go to ISSUE if OK, else FAIL.
- ISSUE: hold core_*_valid and data stable until ready. On the handshake cycle return to IDLE; valid deasserts the following cycle.
- FAIL: build the local response. Alloc: idx=0, fail=1. Free: fail=1. Write it when that response FIFO is not full and no core response is valid on it, then return to IDLE.
- Response mux, per FIFO:
  - we = (core_rsp_valid & ~full) | (local_pending & ~core_rsp_valid & ~full).
  - Core response has priority.
  - Core fail/reason codes pass through unchanged.
  - Never write when full.
- Core responses are forwarded in every FSM state, independent of the dispatch path.
- Throughput: one request per 4 cycles minimum; ISSUE/FAIL stalls are unbounded.
- Reason 0 = OK. Reasons 1..3 are produced only locally.

Test Plan:
1. Alloc {cnt=3,id=0x005}, core_alloc_ready=1 -> alloc_fifo_pop 1 cycle; 2 cycles later core_alloc_valid=1, data {4,0x005}; no response write.
2. Alloc cnt=9 id=0x1FFF -> no core_alloc_valid; alloc_rsp_we=1 with {0x1FFF,0,1,1}. Alloc cnt=0 gives reason 1.
3. Free cases:
   - idx=3276,cnt=1 -> reason 2
   - idx=6,cnt=4 -> reason 3
   - idx=3272,cnt=8 -> reason 2
   - idx=3272,cnt=3 -> issued as {4,3272,id}
4. Both request FIFOs held non-empty, core ready=1 -> grant order alloc, free, alloc, free; pops never overlap.
5. Same-cycle core alloc response and local alloc failure -> core written first, local the next cycle. With alloc_rsp_fifo_full=1 for 10 cycles -> alloc_rsp_we=0 and core_alloc_rsp_ready=0 throughout, both written after full drops.
6. rst_n asserted while ISSUE holds valid with ready=0 -> core_*_valid drops to 0 asynchronously. After release: IDLE, and the next grant is alloc.

Source files
------------

// File: rtl/mmu_req_dispatcher_if.sv
// Bundle of request-FIFO, core issue/response and response-FIFO signals around the
// MMU request dispatcher. master = dispatcher side, slave = surrounding FIFOs and core.
interface mmu_req_dispatcher_if #(
    parameter int unsigned ID_W  = 13,
    parameter int unsigned IDX_W = 15,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned RSN_W = 2
);
    logic                             alloc_fifo_empty;
    logic                             alloc_fifo_pop;
    logic [CNT_W+ID_W-1:0]            alloc_fifo_data;
    logic                             free_fifo_empty;
    logic                             free_fifo_pop;
    logic [CNT_W+IDX_W+ID_W-1:0]      free_fifo_data;

    logic                             core_alloc_valid;
    logic                             core_alloc_ready;
    logic [CNT_W+ID_W-1:0]            core_alloc_data;
    logic                             core_free_valid;
    logic                             core_free_ready;
    logic [CNT_W+IDX_W+ID_W-1:0]      core_free_data;

    logic                             core_alloc_rsp_valid;
    logic                             core_alloc_rsp_ready;
    logic [ID_W+IDX_W+RSN_W:0]        core_alloc_rsp_data;
    logic                             core_free_rsp_valid;
    logic                             core_free_rsp_ready;
    logic [ID_W+RSN_W:0]              core_free_rsp_data;

    logic                             alloc_rsp_we;
    logic [ID_W+IDX_W+RSN_W:0]        alloc_rsp_data;
    logic                             alloc_rsp_fifo_full;
    logic                             free_rsp_we;
    logic [ID_W+RSN_W:0]              free_rsp_data;
    logic                             free_rsp_fifo_full;

    modport master (
        input  alloc_fifo_empty, alloc_fifo_data, free_fifo_empty, free_fifo_data,
        input  core_alloc_ready, core_free_ready,
        input  core_alloc_rsp_valid, core_alloc_rsp_data,
        input  core_free_rsp_valid, core_free_rsp_data,
        input  alloc_rsp_fifo_full, free_rsp_fifo_full,
        output alloc_fifo_pop, free_fifo_pop,
        output core_alloc_valid, core_alloc_data, core_free_valid, core_free_data,
        output core_alloc_rsp_ready, core_free_rsp_ready,
        output alloc_rsp_we, alloc_rsp_data, free_rsp_we, free_rsp_data
    );

    modport slave (
        output alloc_fifo_empty, alloc_fifo_data, free_fifo_empty, free_fifo_data,
        output core_alloc_ready, core_free_ready,
        output core_alloc_rsp_valid, core_alloc_rsp_data,
        output core_free_rsp_valid, core_free_rsp_data,
        output alloc_rsp_fifo_full, free_rsp_fifo_full,
        input  alloc_fifo_pop, free_fifo_pop,
        input  core_alloc_valid, core_alloc_data, core_free_valid, core_free_data,
        input  core_alloc_rsp_ready, core_free_rsp_ready,
        input  alloc_rsp_we, alloc_rsp_data, free_rsp_we, free_rsp_data
    );
endinterface

// File: rtl/mmu_req_dispatcher.sv
// Round-robin dispatcher of alloc/free requests to the allocator core; malformed requests
// are answered locally, muxed behind core responses into the response FIFOs.
module mmu_req_dispatcher #(
    parameter int unsigned ID_W     = 13,
    parameter int unsigned IDX_W    = 15,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned RSN_W    = 2,
    parameter int unsigned PAGE_NUM = 3276
) (
    input logic                  clk,
    input logic                  rst_n,
    mmu_req_dispatcher_if.master io_bus
);

    localparam logic [IDX_W:0] PageLim = (IDX_W+1)'(PAGE_NUM);

    typedef enum logic [2:0] {StIdle, StRd, StChk, StIssue, StFail} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_sel;        // 1: current request is a free
    logic               r_last_free;  // 1: free was granted last, so alloc wins a tie
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [ID_W-1:0]    r_id;
    logic [RSN_W-1:0]   r_reason;

    logic               w_grant;
    logic               w_grant_free;
    logic [CNT_W-1:0]   w_raw_cnt;
    logic [CNT_W-1:0]   w_aligned;
    logic [IDX_W-1:0]   w_idx;
    logic [ID_W-1:0]    w_id;
    logic [RSN_W-1:0]   w_reason;
    logic [IDX_W:0]     w_end;
    logic [IDX_W-1:0]   w_mask;
    logic               w_issue_done;
    logic               w_alloc_local;
    logic               w_free_local;
    logic               w_local_we;

    always_comb begin
        if (r_sel) begin
            w_raw_cnt = io_bus.free_fifo_data[CNT_W+IDX_W+ID_W-1 -: CNT_W];
            w_idx     = io_bus.free_fifo_data[IDX_W+ID_W-1 -: IDX_W];
            w_id      = io_bus.free_fifo_data[ID_W-1:0];
        end else begin
            w_raw_cnt = io_bus.alloc_fifo_data[CNT_W+ID_W-1 -: CNT_W];
            w_idx     = '0;
            w_id      = io_bus.alloc_fifo_data[ID_W-1:0];
        end
    end

    // Round up to a power of two; zero marks an unsupported size.
    always_comb begin
        w_aligned = '0;
        w_reason  = '0;
        case (w_raw_cnt)
            CNT_W'(1):                                   w_aligned = CNT_W'(1);
            CNT_W'(2):                                   w_aligned = CNT_W'(2);
            CNT_W'(3), CNT_W'(4):                        w_aligned = CNT_W'(4);
            CNT_W'(5), CNT_W'(6), CNT_W'(7), CNT_W'(8):  w_aligned = CNT_W'(8);
            default:                                     w_aligned = '0;
        endcase
        w_end  = {1'b0, w_idx} + (IDX_W+1)'(w_aligned);
        w_mask = IDX_W'(w_aligned) - IDX_W'(1);
        if (w_aligned == '0) begin
            w_reason = RSN_W'(1);
        end else if (r_sel && (({1'b0, w_idx} >= PageLim) || (w_end > PageLim))) begin
            w_reason = RSN_W'(2);
        end else if (r_sel && ((w_idx & w_mask) != '0)) begin
            w_reason = RSN_W'(3);
        end
    end

    assign w_issue_done  = (r_state == StIssue) &&
                           (r_sel ? io_bus.core_free_ready : io_bus.core_alloc_ready);
    assign w_alloc_local = (r_state == StFail) && !r_sel;
    assign w_free_local  = (r_state == StFail) && r_sel;
    assign w_local_we    = r_sel ?
        (w_free_local && !io_bus.core_free_rsp_valid && !io_bus.free_rsp_fifo_full) :
        (w_alloc_local && !io_bus.core_alloc_rsp_valid && !io_bus.alloc_rsp_fifo_full);

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_free = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!io_bus.alloc_fifo_empty || !io_bus.free_fifo_empty) begin
                    w_grant      = 1'b1;
                    w_grant_free = (!io_bus.alloc_fifo_empty && !io_bus.free_fifo_empty) ?
                                   !r_last_free : io_bus.alloc_fifo_empty;
                    w_state_nxt  = StRd;
                end
            end
            StRd:    w_state_nxt = StChk;
            StChk:   w_state_nxt = (w_reason == '0) ? StIssue : StFail;
            StIssue: if (w_issue_done) w_state_nxt = StIdle;
            StFail:  if (w_local_we) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sel       <= 1'b0;
            r_last_free <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_id        <= '0;
            r_reason    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_sel       <= w_grant_free;
                r_last_free <= w_grant_free;
            end
            if (r_state == StChk) begin
                r_cnt    <= w_aligned;
                r_idx    <= w_idx;
                r_id     <= w_id;
                r_reason <= w_reason;
            end
        end
    end

    assign io_bus.alloc_fifo_pop   = (r_state == StRd) && !r_sel;
    assign io_bus.free_fifo_pop    = (r_state == StRd) && r_sel;
    assign io_bus.core_alloc_valid = (r_state == StIssue) && !r_sel;
    assign io_bus.core_free_valid  = (r_state == StIssue) && r_sel;
    assign io_bus.core_alloc_data  = {r_cnt, r_id};
    assign io_bus.core_free_data   = {r_cnt, r_idx, r_id};

    // Core responses always win the FIFO write port; a local failure waits behind them.
    assign io_bus.core_alloc_rsp_ready = !io_bus.alloc_rsp_fifo_full;
    assign io_bus.core_free_rsp_ready  = !io_bus.free_rsp_fifo_full;
    assign io_bus.alloc_rsp_we = !io_bus.alloc_rsp_fifo_full &&
                                 (io_bus.core_alloc_rsp_valid || w_alloc_local);
    assign io_bus.free_rsp_we  = !io_bus.free_rsp_fifo_full &&
                                 (io_bus.core_free_rsp_valid || w_free_local);
    assign io_bus.alloc_rsp_data = io_bus.core_alloc_rsp_valid ? io_bus.core_alloc_rsp_data :
                                   {r_id, {IDX_W{1'b0}}, r_reason, 1'b1};
    assign io_bus.free_rsp_data  = io_bus.core_free_rsp_valid ? io_bus.core_free_rsp_data :
                                   {r_id, r_reason, 1'b1};

endmodule

// File: tb/tb_mmu_req_dispatcher.sv
// Randomised and directed bench for mmu_req_dispatcher against a queue-based reference
// model of request outcomes, grant order and response-FIFO muxing.
module tb_mmu_req_dispatcher;
    localparam int ID_W = 13, IDX_W = 15, CNT_W = 4, RSN_W = 2, PAGE_NUM = 3276;
    localparam int AW = CNT_W + ID_W, FW = CNT_W + IDX_W + ID_W;
    localparam int ARW = ID_W + IDX_W + RSN_W + 1, FRW = ID_W + RSN_W + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmu_req_dispatcher_if #(.ID_W(ID_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .RSN_W(RSN_W)) bus ();

    mmu_req_dispatcher #(
        .ID_W(ID_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .RSN_W(RSN_W), .PAGE_NUM(PAGE_NUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    // Request FIFO models: data appears the cycle after a pop.
    logic [AW-1:0] amem [0:255];
    logic [FW-1:0] fmem [0:255];
    int unsigned awr = 0, ard = 0, fwr = 0, frd = 0;
    assign bus.alloc_fifo_empty = (awr == ard);
    assign bus.free_fifo_empty  = (fwr == frd);

    logic [63:0] exp_ai[$], exp_fi[$], exp_al[$], exp_fl[$];
    bit          exp_g[$];
    int n_chk = 0, n_pass = 0, cyc = 0;
    bit rand_en = 1'b0, chk_grant = 1'b0;
    bit s_pop_a, s_pop_f, s_aval, s_arsp_acc, s_frsp_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int unsigned align_of(input int unsigned c);
        int unsigned a;
        if (c == 0 || c > 8) return 0;
        a = 1;
        while (a < c) a = a * 2;
        return a;
    endfunction

    task automatic push_alloc(input int unsigned cnt, input int unsigned id);
        int unsigned a;
        amem[awr % 256] = {CNT_W'(cnt), ID_W'(id)};
        awr++;
        a = align_of(cnt);
        if (a == 0) exp_al.push_back(64'({ID_W'(id), IDX_W'(0), RSN_W'(1), 1'b1}));
        else        exp_ai.push_back(64'({CNT_W'(a), ID_W'(id)}));
    endtask

    task automatic push_free(input int unsigned cnt, input int unsigned idx,
                             input int unsigned id);
        int unsigned a, rsn;
        fmem[fwr % 256] = {CNT_W'(cnt), IDX_W'(idx), ID_W'(id)};
        fwr++;
        a = align_of(cnt);
        rsn = 0;
        if (a == 0) rsn = 1;
        else if (idx >= PAGE_NUM || idx + a > PAGE_NUM) rsn = 2;
        else if (idx % a != 0) rsn = 3;
        if (rsn != 0) exp_fl.push_back(64'({ID_W'(id), RSN_W'(rsn), 1'b1}));
        else          exp_fi.push_back(64'({CNT_W'(a), IDX_W'(idx), ID_W'(id)}));
    endtask

    task automatic monitor();
        logic [63:0] e;
        cyc++;
        s_pop_a = bus.alloc_fifo_pop;
        s_pop_f = bus.free_fifo_pop;
        s_aval  = bus.core_alloc_valid;
        if (s_pop_a || s_pop_f) begin
            check("pop_one_hot", 64'(s_pop_a) + 64'(s_pop_f), 64'd1);
            if (chk_grant) begin
                e = (exp_g.size() > 0) ? 64'(exp_g.pop_front()) : 64'd2;
                check("grant_order", 64'(s_pop_f), e);
            end
        end
        if (bus.core_alloc_valid && bus.core_alloc_ready) begin
            e = (exp_ai.size() > 0) ? exp_ai.pop_front() : 64'hBAD;
            check("alloc_issue", 64'(bus.core_alloc_data), e);
        end
        if (bus.core_free_valid && bus.core_free_ready) begin
            e = (exp_fi.size() > 0) ? exp_fi.pop_front() : 64'hBAD;
            check("free_issue", 64'(bus.core_free_data), e);
        end
        check("arsp_ready", 64'(bus.core_alloc_rsp_ready), 64'(!bus.alloc_rsp_fifo_full));
        s_arsp_acc = bus.core_alloc_rsp_valid && !bus.alloc_rsp_fifo_full;
        if (bus.alloc_rsp_fifo_full) begin
            check("arsp_we_full", 64'(bus.alloc_rsp_we), 64'd0);
        end else if (bus.core_alloc_rsp_valid) begin
            check("arsp_we_core", 64'(bus.alloc_rsp_we), 64'd1);
            check("arsp_core_data", 64'(bus.alloc_rsp_data), 64'(bus.core_alloc_rsp_data));
        end else if (bus.alloc_rsp_we) begin
            e = (exp_al.size() > 0) ? exp_al.pop_front() : 64'hBAD;
            check("arsp_local", 64'(bus.alloc_rsp_data), e);
        end
        check("frsp_ready", 64'(bus.core_free_rsp_ready), 64'(!bus.free_rsp_fifo_full));
        s_frsp_acc = bus.core_free_rsp_valid && !bus.free_rsp_fifo_full;
        if (bus.free_rsp_fifo_full) begin
            check("frsp_we_full", 64'(bus.free_rsp_we), 64'd0);
        end else if (bus.core_free_rsp_valid) begin
            check("frsp_we_core", 64'(bus.free_rsp_we), 64'd1);
            check("frsp_core_data", 64'(bus.free_rsp_data), 64'(bus.core_free_rsp_data));
        end else if (bus.free_rsp_we) begin
            e = (exp_fl.size() > 0) ? exp_fl.pop_front() : 64'hBAD;
            check("frsp_local", 64'(bus.free_rsp_data), e);
        end
    endtask

    task automatic drive_rand();
        bus.core_alloc_ready    = ($urandom_range(0, 3) != 0);
        bus.core_free_ready     = ($urandom_range(0, 3) != 0);
        bus.alloc_rsp_fifo_full = ($urandom_range(0, 4) == 0);
        bus.free_rsp_fifo_full  = ($urandom_range(0, 4) == 0);
        if (!bus.core_alloc_rsp_valid && $urandom_range(0, 3) == 0) begin
            bus.core_alloc_rsp_valid = 1'b1;
            bus.core_alloc_rsp_data  = ARW'($urandom());
        end
        if (!bus.core_free_rsp_valid && $urandom_range(0, 3) == 0) begin
            bus.core_free_rsp_valid = 1'b1;
            bus.core_free_rsp_data  = FRW'($urandom());
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (s_pop_a) begin bus.alloc_fifo_data = amem[ard % 256]; ard++; end
        if (s_pop_f) begin bus.free_fifo_data = fmem[frd % 256]; frd++; end
        if (s_arsp_acc) bus.core_alloc_rsp_valid = 1'b0;
        if (s_frsp_acc) bus.core_free_rsp_valid = 1'b0;
        if (rand_en) drive_rand();
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int left;
        for (int i = 0; i < bound; i++) begin
            left = exp_ai.size() + exp_fi.size() + exp_al.size() + exp_fl.size() + exp_g.size();
            if (left == 0) break;
            tick();
        end
        repeat (4) tick();
        left = exp_ai.size() + exp_fi.size() + exp_al.size() + exp_fl.size() + exp_g.size();
        check(tag, 64'(left), 64'd0);
    endtask

    initial begin
        int t_pop, t_val, npop, na, nf, np;
        bus.alloc_fifo_data = '0;  bus.free_fifo_data = '0;
        bus.core_alloc_ready = 1'b1;  bus.core_free_ready = 1'b1;
        bus.core_alloc_rsp_valid = 1'b0;  bus.core_alloc_rsp_data = '0;
        bus.core_free_rsp_valid = 1'b0;   bus.core_free_rsp_data = '0;
        bus.alloc_rsp_fifo_full = 1'b0;   bus.free_rsp_fifo_full = 1'b0;

        repeat (3) tick();
        check("rst_ctrl", 64'({bus.alloc_fifo_pop, bus.free_fifo_pop, bus.core_alloc_valid,
                               bus.core_free_valid, bus.alloc_rsp_we, bus.free_rsp_we}), 64'd0);
        check("rst_adata", 64'(bus.core_alloc_data), 64'd0);
        check("rst_fdata", 64'(bus.core_free_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single alloc: pop lasts one cycle, valid two cycles after it
        push_alloc(3, 13'h005);
        t_pop = -1; t_val = -1; npop = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_pop_a) begin npop++; if (t_pop < 0) t_pop = cyc; end
            if (s_aval && t_val < 0) t_val = cyc;
        end
        check("t1_pop_cycles", 64'(npop), 64'd1);
        check("t1_valid_lat", 64'(t_val - t_pop), 64'd2);
        wait_drain("t1_drain", 50);

        push_alloc(9, 13'h1FFF);
        push_alloc(0, 13'h0AB);
        wait_drain("t2_drain", 100);

        push_free(1, 3276, 13'h011);
        push_free(4, 6, 13'h022);
        push_free(8, 3272, 13'h033);
        push_free(3, 3272, 13'h044);
        wait_drain("t3_drain", 200);

        // Local failure blocked by full, then collides with a core response
        bus.alloc_rsp_fifo_full  = 1'b1;
        bus.core_alloc_rsp_valid = 1'b1;
        bus.core_alloc_rsp_data  = ARW'(31'h1234_5671);
        push_alloc(12, 13'h0777);
        repeat (10) tick();
        check("t5_held", 64'(exp_al.size()), 64'd1);
        bus.alloc_rsp_fifo_full = 1'b0;
        tick();
        tick();
        check("t5_local_next", 64'(exp_al.size()), 64'd0);
        wait_drain("t5_drain", 50);

        // Async reset while an issue is stalled
        bus.core_alloc_ready = 1'b0;
        push_alloc(5, 13'h0123);
        for (int i = 0; i < 20 && !s_aval; i++) tick();
        check("t6_valid_seen", 64'(s_aval), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_drop", 64'(bus.core_alloc_valid), 64'd0);
        exp_ai.delete();

        // Both FIFOs preloaded: grants alternate starting with alloc
        na = $urandom_range(20, 40);
        nf = $urandom_range(20, 40);
        for (int i = 0; i < na; i++) push_alloc($urandom_range(0, 10), $urandom_range(0, 8191));
        for (int i = 0; i < nf; i++) begin
            case ($urandom_range(0, 2))
                0:       push_free($urandom_range(0, 10), $urandom_range(0, 4095),
                                   $urandom_range(0, 8191));
                1:       push_free($urandom_range(0, 10), $urandom_range(0, 409) * 8,
                                   $urandom_range(0, 8191));
                default: push_free($urandom_range(0, 10), PAGE_NUM - $urandom_range(0, 9),
                                   $urandom_range(0, 8191));
            endcase
        end
        np = (na < nf) ? na : nf;
        for (int i = 0; i < np; i++) begin exp_g.push_back(1'b0); exp_g.push_back(1'b1); end
        for (int i = np; i < na; i++) exp_g.push_back(1'b0);
        for (int i = np; i < nf; i++) exp_g.push_back(1'b1);
        chk_grant = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        rand_en = 1'b1;
        wait_drain("rand_drain", 20000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
